// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60Hz VGA timing constants and frame-buffer geometry
package vga_timing_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam int H_SYNC_START = H_VISIBLE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_VISIBLE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  localparam int SCALE_SHIFT = 2;
  localparam int FB_W        = 160;
  localparam int FB_H        = 120;
  localparam int FB_ADDR_W   = 15;
  localparam int CNT_W       = 10;

  // Each fb pixel covers a 4x4 block, so drop the two LSBs of each counter.
  function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [CNT_W-1:0] h,
                                                   input logic [CNT_W-1:0] v);
    return {v[8:2], h[9:2]};
  endfunction

endpackage

// File: rtl/vga_signal_gen_if.sv
// rtl/vga_signal_gen_if.sv - VGA output pins and frame-buffer port B read bus
interface vga_signal_gen_if;
  import vga_timing_pkg::*;

  logic                 VGA_HS;
  logic                 VGA_VS;
  logic [7:0]           VGA_COLOUR;
  logic                 MEM_CLK;
  logic [FB_ADDR_W-1:0] MEM_ADDR;
  logic                 MEM_DATA;

  modport master (
    output VGA_HS, VGA_VS, VGA_COLOUR, MEM_CLK, MEM_ADDR,
    input  MEM_DATA
  );

  modport slave (
    input  VGA_HS, VGA_VS, VGA_COLOUR, MEM_CLK, MEM_ADDR,
    output MEM_DATA
  );

endinterface

// File: rtl/vga_counter.sv
// rtl/vga_counter.sv - wrap counter 0..MAX with enable and terminal-count flag
module vga_counter #(
  parameter int MAX = 799,
  parameter int W   = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);

  logic [W-1:0] count_q, count_d;

  assign tc    = (count_q == W'(MAX));
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = tc ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vga_signal_gen.sv
// rtl/vga_signal_gen.sv - VGA timing generator reading a 1bpp 160x120 frame buffer
module vga_signal_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VIS    = H_VISIBLE,
  parameter int H_FPORCH = H_FP,
  parameter int H_SYNC_W = H_SYNC,
  parameter int H_BPORCH = H_BP,
  parameter int V_VIS    = V_VISIBLE,
  parameter int V_FPORCH = V_FP,
  parameter int V_SYNC_W = V_SYNC,
  parameter int V_BPORCH = V_BP
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [15:0]      CONFIG_COLOURS,
  vga_signal_gen_if.master vga
);

  localparam int H_TOT = H_VIS + H_FPORCH + H_SYNC_W + H_BPORCH;
  localparam int V_TOT = V_VIS + V_FPORCH + V_SYNC_W + V_BPORCH;
  localparam logic [CNT_W-1:0] H_VIS_C = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] H_SS_C  = CNT_W'(H_VIS + H_FPORCH);
  localparam logic [CNT_W-1:0] H_SE_C  = CNT_W'(H_VIS + H_FPORCH + H_SYNC_W - 1);
  localparam logic [CNT_W-1:0] V_VIS_C = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0] V_SS_C  = CNT_W'(V_VIS + V_FPORCH);
  localparam logic [CNT_W-1:0] V_SE_C  = CNT_W'(V_VIS + V_FPORCH + V_SYNC_W - 1);

  logic             pix_en_q, pix_en_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic [7:0]       colour_q, colour_d;
  logic [CNT_W-1:0] hcount, vcount;
  logic             h_tc, v_tc;
  logic             active, raw_hs, raw_vs;

  vga_counter #(.MAX(H_TOT - 1), .W(CNT_W)) u_hcnt (
    .clk(CLK), .rst_n(RESET), .en(pix_en_q), .count(hcount), .tc(h_tc)
  );

  vga_counter #(.MAX(V_TOT - 1), .W(CNT_W)) u_vcnt (
    .clk(CLK), .rst_n(RESET), .en(pix_en_q & h_tc), .count(vcount), .tc(v_tc)
  );

  assign active = (hcount < H_VIS_C) && (vcount < V_VIS_C);
  assign raw_hs = !((hcount >= H_SS_C) && (hcount <= H_SE_C));
  assign raw_vs = !((vcount >= V_SS_C) && (vcount <= V_SE_C));

  // The RAM has already returned this counter's pixel by the time the counters
  // advance, so registering here is the one-pixel delay stage for all outputs.
  always_comb begin
    pix_en_d = ~pix_en_q;
    hs_d     = hs_q;
    vs_d     = vs_q;
    colour_d = colour_q;
    if (pix_en_q) begin
      hs_d     = raw_hs;
      vs_d     = raw_vs;
      colour_d = active ? (vga.MEM_DATA ? CONFIG_COLOURS[15:8] : CONFIG_COLOURS[7:0]) : 8'h00;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pix_en_q <= 1'b0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      colour_q <= 8'h00;
    end else begin
      pix_en_q <= pix_en_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      colour_q <= colour_d;
    end
  end

  assign vga.VGA_HS     = hs_q;
  assign vga.VGA_VS     = vs_q;
  assign vga.VGA_COLOUR = colour_q;
  assign vga.MEM_CLK    = pix_en_q;
  assign vga.MEM_ADDR   = active ? fb_addr(hcount, vcount) : '0;

endmodule

// File: tb/tb_vga_signal_gen.sv
// tb/tb_vga_signal_gen.sv - self-checking bench: full-size and reduced-geometry generators vs pixel model
`timescale 1ns/1ps
module tb_vga_signal_gen;

  typedef struct packed {
    int hv; int hfp; int hs; int hbp;
    int vv; int vfp; int vs; int vbp;
  } geo_t;

  geo_t g_full  = '{640, 16, 96, 48, 480, 10, 2, 33};
  geo_t g_small = '{64, 8, 16, 8, 32, 2, 2, 4};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cfg = 16'hE01C;
  logic [15:0] cfg_px = 16'hE01C;
  bit          fb [0:32767];
  int unsigned e = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  bit          blank_f = 1'b0;
  bit          blank_s = 1'b0;
  int unsigned e0;

  always #10 clk = ~clk;

  vga_signal_gen_if vf();
  vga_signal_gen_if vsm();

  vga_signal_gen dut_full (
    .CLK(clk), .RESET(rst_n), .CONFIG_COLOURS(cfg), .vga(vf)
  );

  vga_signal_gen #(
    .H_VIS(64), .H_FPORCH(8), .H_SYNC_W(16), .H_BPORCH(8),
    .V_VIS(32), .V_FPORCH(2), .V_SYNC_W(2), .V_BPORCH(4)
  ) dut_small (
    .CLK(clk), .RESET(rst_n), .CONFIG_COLOURS(cfg), .vga(vsm)
  );

  // Frame-buffer RAM models: data registered on MEM_CLK rise, X while the pixel is blanked
  always @(posedge vf.MEM_CLK)  vf.MEM_DATA  <= blank_f ? 1'bx : fb[vf.MEM_ADDR];
  always @(posedge vsm.MEM_CLK) vsm.MEM_DATA <= blank_s ? 1'bx : fb[vsm.MEM_ADDR];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) e <= 0;
    else        e <= e + 1;
  end

  // Colour config in force at each pixel-advance edge (edges that make e even)
  always @(posedge clk) if (rst_n && e % 2 == 1) cfg_px <= cfg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic bit is_active(input geo_t g, input int unsigned k);
    int ht = g.hv + g.hfp + g.hs + g.hbp;
    int vt = g.vv + g.vfp + g.vs + g.vbp;
    return (int'(k % ht) < g.hv) && (int'((k / ht) % vt) < g.vv);
  endfunction

  task automatic check_inst(input string tag, input geo_t g, input logic hs, input logic vs,
                            input logic [7:0] col, input logic mclk, input logic [14:0] addr);
    int ht = g.hv + g.hfp + g.hs + g.hbp;
    int vt = g.vv + g.vfp + g.vs + g.vbp;
    int x, y, xk, yk;
    int unsigned p, k;
    logic ehs = 1'b1, evs = 1'b1;
    logic [7:0] ecol = 8'h00;
    logic [14:0] eaddr = '0;
    if (e >= 2) begin
      p = e / 2 - 1;
      x = int'(p % ht);
      y = int'((p / ht) % vt);
      ehs = !(x >= g.hv + g.hfp && x < g.hv + g.hfp + g.hs);
      evs = !(y >= g.vv + g.vfp && y < g.vv + g.vfp + g.vs);
      if (x < g.hv && y < g.vv)
        ecol = fb[(y / 4) * 256 + x / 4] ? cfg_px[15:8] : cfg_px[7:0];
    end
    k = e / 2;
    if (is_active(g, k)) begin
      xk = int'(k % ht);
      yk = int'((k / ht) % vt);
      eaddr = 15'((yk / 4) * 256 + xk / 4);
    end
    chk({tag, "_hs"}, 32'(hs), 32'(ehs));
    chk({tag, "_vs"}, 32'(vs), 32'(evs));
    chk({tag, "_colour"}, 32'(col), 32'(ecol));
    chk({tag, "_mem_clk"}, 32'(mclk), 32'(e % 2));
    chk({tag, "_mem_addr"}, 32'(addr), 32'(eaddr));
  endtask

  always @(negedge clk) begin
    check_inst("full", g_full, vf.VGA_HS, vf.VGA_VS, vf.VGA_COLOUR, vf.MEM_CLK, vf.MEM_ADDR);
    check_inst("small", g_small, vsm.VGA_HS, vsm.VGA_VS, vsm.VGA_COLOUR, vsm.MEM_CLK, vsm.MEM_ADDR);
    blank_f = !is_active(g_full, e / 2);
    blank_s = !is_active(g_small, e / 2);
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_full_hs"}, 32'(vf.VGA_HS), 32'd1);
    chk({tag, "_full_vs"}, 32'(vf.VGA_VS), 32'd1);
    chk({tag, "_full_colour"}, 32'(vf.VGA_COLOUR), 32'h0);
    chk({tag, "_full_mem_clk"}, 32'(vf.MEM_CLK), 32'd0);
    chk({tag, "_small_hs"}, 32'(vsm.VGA_HS), 32'd1);
    chk({tag, "_small_colour"}, 32'(vsm.VGA_COLOUR), 32'h0);
  endtask

  // mode: 0 all ones, 1 all zeros, 2 single bit at row 1 col 2, 3 random
  task automatic do_reset(input int mode);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    for (int i = 0; i < 32768; i++) begin
      case (mode)
        0:       fb[i] = 1'b1;
        1:       fb[i] = 1'b0;
        2:       fb[i] = (i == 1 * 256 + 2);
        default: fb[i] = 1'($urandom);
      endcase
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_hs(input logic lvl, input int limit);
    for (int i = 0; i < limit && vf.VGA_HS !== lvl; i++) @(negedge clk);
  endtask

  task automatic wait_vs_small(input logic lvl, input int limit);
    for (int i = 0; i < limit && vsm.VGA_VS !== lvl; i++) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 32768; i++) fb[i] = 1'b1;
    #100;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Line timing on the full-size generator
    wait_hs(1'b0, 3000);
    chk("first_hs_fall_edges", e, 32'd1314);
    e0 = e;
    wait_hs(1'b1, 3000);
    chk("hs_low_edges", e - e0, 32'd192);
    wait_hs(1'b0, 3000);
    chk("hs_period_edges", e - e0, 32'd1600);

    do_reset(1);
    repeat (2000) @(negedge clk);

    // Single lit fb pixel; frame timing on the reduced-geometry generator
    do_reset(2);
    wait_vs_small(1'b0, 8000);
    chk("first_vs_fall_edges", e, 32'd6530);
    e0 = e;
    wait_vs_small(1'b1, 8000);
    chk("vs_low_edges", e - e0, 32'd384);
    wait_vs_small(1'b0, 9000);
    chk("vs_period_edges", e - e0, 32'd7680);

    // Random frame buffer and colours changing between pixels
    do_reset(3);
    repeat (6000) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) cfg = 16'($urandom);
    end

    // Mid-line reset then restart timing
    cfg = 16'hE01C;
    do_reset(0);
    for (int i = 0; i < 5000 && e < 2 * (2 * 800 + 300); i++) @(negedge clk);
    chk("reached_mid_line", e, 32'(2 * (2 * 800 + 300)));
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_line_reset");
    @(negedge clk);
    rst_n = 1'b1;
    wait_hs(1'b0, 3000);
    chk("restart_hs_fall_edges", e, 32'd1314);
    repeat (200) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
